// File: rtl/systolic_writeback_pkg.sv
// Shared width helpers and row state type for the systolic result writeback path.
package systolic_pkg;

    // Widths never collapse to zero, even for degenerate 1-entry ranges.
    function automatic int clog2Min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    function automatic int addrW(input int m, input int n1);
        return clog2Min1((m * m) / n1);
    endfunction

    function automatic int tileW(input int m, input int n1, input int n2);
        return clog2Min1((m / n1) * (m / n2));
    endfunction

    function automatic int beatW(input int n2);
        return clog2Min1(n2);
    endfunction

    typedef enum logic {
        ROW_ACTIVE   = 1'b0,
        ROW_COMPLETE = 1'b1
    } rowState_t;

endpackage

// File: rtl/systolic_writeback_if.sv
// Result-drain bus between the systolic array edge and the banked result memory.
interface systolic_writeback_if
    import systolic_pkg::*;
#(
    parameter int D_W_ACC = 16,
    parameter int N1      = 4,
    parameter int N2      = 4,
    parameter int M       = 8
);
    localparam int AW = addrW(M, N1);

    logic                          i_clear;
    logic [N1-1:0][D_W_ACC-1:0]    i_D;
    logic [N1-1:0]                 i_valid_D;
    logic [N1-1:0]                 o_wr_en;
    logic [N1-1:0][AW-1:0]         o_wr_addr;
    logic [N1-1:0][D_W_ACC-1:0]    o_wr_data;
    logic                          o_done;
    logic                          o_overflow;

    modport master (
        output i_clear, i_D, i_valid_D,
        input  o_wr_en, o_wr_addr, o_wr_data, o_done, o_overflow
    );

    modport slave (
        input  i_clear, i_D, i_valid_D,
        output o_wr_en, o_wr_addr, o_wr_data, o_done, o_overflow
    );
endinterface

// File: rtl/systolic_writeback_drain_row.sv
// One array row: beat/tile counters and the registered write port for its bank.
module drain_row
    import systolic_pkg::*;
#(
    parameter  int D_W_ACC = 16,
    parameter  int N1      = 4,
    parameter  int N2      = 4,
    parameter  int M       = 8,
    localparam int AW      = addrW(M, N1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_valid,
    input  logic [D_W_ACC-1:0] i_d,
    output logic               o_wr_en,
    output logic [AW-1:0]      o_wr_addr,
    output logic [D_W_ACC-1:0] o_wr_data,
    output logic               o_complete,
    output logic               o_overflow
);
    localparam int TW    = tileW(M, N1, N2);
    localparam int BW    = beatW(N2);
    localparam int TILES = (M / N1) * (M / N2);
    localparam int TPS   = M / N2;

    rowState_t         r_state;
    logic [BW-1:0]     r_k;
    logic [TW-1:0]     r_t;
    logic              r_wrEn;
    logic [AW-1:0]     r_wrAddr;
    logic [D_W_ACC-1:0] r_wrData;
    logic              r_ovf;
    logic [AW-1:0]     w_addr;

    // Beats arrive last column first, so the column offset counts down within a tile.
    always_comb begin
        w_addr = AW'((int'(r_t) / TPS) * M + (int'(r_t) % TPS) * N2 + (N2 - 1 - int'(r_k)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ROW_ACTIVE;
            r_k      <= '0;
            r_t      <= '0;
            r_wrEn   <= 1'b0;
            r_wrAddr <= '0;
            r_wrData <= '0;
            r_ovf    <= 1'b0;
        end else if (i_clear) begin
            r_state  <= ROW_ACTIVE;
            r_k      <= '0;
            r_t      <= '0;
            r_wrEn   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (i_valid && r_state == ROW_COMPLETE) begin
            r_wrEn   <= 1'b0;
            r_ovf    <= 1'b1;
        end else if (i_valid) begin
            r_wrEn   <= 1'b1;
            r_wrAddr <= w_addr;
            r_wrData <= i_d;
            if (r_k == BW'(N2 - 1)) begin
                r_k <= '0;
                // The tile counter parks on its last value once the row is full.
                if (r_t == TW'(TILES - 1)) begin
                    r_state <= ROW_COMPLETE;
                end else begin
                    r_t <= r_t + 1'b1;
                end
            end else begin
                r_k <= r_k + 1'b1;
            end
        end else begin
            r_wrEn   <= 1'b0;
        end
    end

    assign o_wr_en    = r_wrEn;
    assign o_wr_addr  = r_wrAddr;
    assign o_wr_data  = r_wrData;
    assign o_complete = (r_state == ROW_COMPLETE);
    assign o_overflow = r_ovf;
endmodule

// File: rtl/systolic_writeback.sv
// Drains the systolic array's last column into N1 result banks, one row per bank.
module systolic_writeback
    import systolic_pkg::*;
#(
    parameter int D_W_ACC = 16,
    parameter int N1      = 4,
    parameter int N2      = 4,
    parameter int M       = 8
) (
    input  logic clk,
    input  logic rst,
    systolic_writeback_if.slave bus
);
    localparam int AW = addrW(M, N1);

    logic               w_wrEn    [N1];
    logic [AW-1:0]      w_wrAddr  [N1];
    logic [D_W_ACC-1:0] w_wrData  [N1];
    logic               w_complete[N1];
    logic               w_ovf     [N1];

    for (genvar g = 0; g < N1; g++) begin : g_row
        drain_row #(
            .D_W_ACC(D_W_ACC),
            .N1     (N1),
            .N2     (N2),
            .M      (M)
        ) u_row (
            .clk       (clk),
            .rst       (rst),
            .i_clear   (bus.i_clear),
            .i_valid   (bus.i_valid_D[g]),
            .i_d       (bus.i_D[g]),
            .o_wr_en   (w_wrEn[g]),
            .o_wr_addr (w_wrAddr[g]),
            .o_wr_data (w_wrData[g]),
            .o_complete(w_complete[g]),
            .o_overflow(w_ovf[g])
        );
    end

    // Per-row flags are already registered, so done lines up with the final write strobe.
    always_comb begin
        bus.o_wr_en    = '0;
        bus.o_wr_addr  = '0;
        bus.o_wr_data  = '0;
        bus.o_done     = 1'b1;
        bus.o_overflow = 1'b0;
        for (int i = 0; i < N1; i++) begin
            bus.o_wr_en[i]   = w_wrEn[i];
            bus.o_wr_addr[i] = w_wrAddr[i];
            bus.o_wr_data[i] = w_wrData[i];
            bus.o_done       = bus.o_done & w_complete[i];
            bus.o_overflow   = bus.o_overflow | w_ovf[i];
        end
    end
endmodule

// File: doc/systolic_writeback.md
SYSTOLIC_WRITEBACK -- requirements
Module: systolic_writeback

Interface
REQ-001 SHALL have parameter D_W_ACC, default 16, meaning result data width.
REQ-002 SHALL have parameter N1, default 4, meaning array rows and number of output banks.
REQ-003 SHALL have parameter N2, default 4, meaning array columns and beats per row burst.
REQ-004 SHALL have parameter M, default 8, meaning square matrix dimension; M divisible by N1 and N2.
REQ-005 SHALL have port clk, input, 1 bit: clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port clear, input, 1 bit: synchronous restart of all counters and flags for a new matrix.
REQ-008 SHALL have port D, input, N1 x D_W_ACC: per-row result data from the array's last column.
REQ-009 SHALL have port valid_D, input, N1 bits: per-row qualifier for D.
REQ-010 SHALL have port wr_en, output, N1 bits: per-bank write strobe.
REQ-011 SHALL have port wr_addr, output, N1 x clog2(M*M/N1): per-bank write address.
REQ-012 SHALL have port wr_data, output, N1 x D_W_ACC: per-bank write data.
REQ-013 SHALL have port done, output, 1 bit: all tiles on all rows written.
REQ-014 SHALL have port overflow, output, 1 bit: sticky; a valid beat arrived after its row was complete.

Function
REQ-015 SHALL handle each row i independently; row skew between rows requires no alignment.
REQ-016 SHALL keep, per row, a beat counter k (0..N2-1) and a tile counter t (0..(M/N1)*(M/N2)-1).
REQ-017 SHALL, on a valid_D[i] beat, register wr_en[i]=1, wr_data[i]=D[i], wr_addr[i]=s*M + p*N2 + (N2-1-k), where s=t/(M/N2) and p=t%(M/N2); latency exactly 1 cycle.
REQ-018 SHALL drive wr_en[i]=0 in every cycle following a cycle with no valid beat on row i; wr_addr/wr_data then hold their last value.
REQ-019 SHALL advance k on each beat; on k=N2-1, wrap k to 0 and increment t.
REQ-020 SHALL mark row i complete when t wraps past (M/N1)*(M/N2)-1; t does not wrap to 0.
REQ-021 SHALL, for a beat on a complete row, suppress wr_en[i] and set overflow.
REQ-022 SHALL set done one cycle after the last write of the last incomplete row, i.e. aligned with that write's wr_en; done is sticky until clear or rst.
REQ-023 SHALL accept non-contiguous beats within a burst; k is counted per beat, not per cycle.
REQ-024 SHALL give clear priority over a coincident valid beat: the beat is dropped, no write occurs, and counters go to 0.
REQ-025 SHALL allow the same beat index on all rows in one cycle, giving N1 parallel writes.

Reset
REQ-026 SHALL, on rst, set wr_en=0, wr_addr=0, wr_data=0, done=0, overflow=0, and all k and t to 0 and all rows incomplete.
REQ-027 SHALL, on rst mid-matrix, abandon partial bursts; the next beat is treated as k=0, t=0.
REQ-028 SHALL give rst the same effect as clear, and rst overrides all other inputs.

Structure
REQ-029 SHALL define address, tile and beat widths as functions in shared package systolic_pkg, using clog2 with a minimum width of 1.
REQ-030 SHALL place per-row counters and the write register in sub-module drain_row, instantiated N1 times.
REQ-031 SHALL produce done and overflow at the top level from per-row complete and overflow signals.

Verification (M=8, N1=N2=4)
REQ-032 SHALL cover single burst, row 0: D=10,11,12,13 over 4 cycles -> writes to addr 3,2,1,0 with data 10..13, each one cycle after its beat.
REQ-033 SHALL cover skewed rows: row i starts i cycles after row 0 -> each bank gets an identical address sequence, offset by i cycles.
REQ-034 SHALL cover full matrix: 4 tiles x 4 beats per row -> 16 writes per bank covering addresses 0..15 exactly once; done rises with the final write.
REQ-035 SHALL cover overflow: one extra beat on row 2 after done -> no wr_en[2], overflow=1, done stays 1.
REQ-036 SHALL cover clear coincident with a beat mid-tile 1: no write, and the next beat writes addr 3 with done=0.
REQ-037 SHALL cover gapped beats: valid pattern 1,0,0,1,1,0,1 -> addrs 3,2,1,0 with wr_en only in cycles after valid beats.
